// File: rtl/csr_irq_unit.sv
// csr_irq_unit: machine-mode CSR file and interrupt controller for the
// three-stage RV32 pipeline. Executes CSRRW/CSRRS/CSRRC, samples interrupt
// lines into mip, picks the highest-priority pending interrupt and drives the
// fetch PC redirect for trap entry and mret.
module csr_irq_unit #(
    parameter int NUM_PLAT_IRQ = 4,
    parameter bit HAS_COUNTERS = 1'b1
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [11:0]                                     csr_addr,
    input  logic [1:0]                                      csr_op,
    input  logic [31:0]                                     csr_wdata,
    output logic [31:0]                                     csr_rdata,
    output logic                                            csr_illegal,
    input  logic [31:0]                                     pc_i,
    input  logic                                            instr_retire,
    input  logic                                            is_mret,
    input  logic                                            timer_irq,
    input  logic                                            sw_irq,
    input  logic                                            ext_irq,
    input  logic [((NUM_PLAT_IRQ > 0) ? NUM_PLAT_IRQ : 1)-1:0] plat_irq,
    output logic                                            redirect_valid,
    output logic [31:0]                                     redirect_pc,
    output logic                                            trap_taken
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    // Platform lines occupy mip/mie bits 16 upwards.
    localparam logic [31:0] PLAT_MASK = (NUM_PLAT_IRQ == 0) ? 32'h0 :
                                        ((32'hFFFF_FFFF >> (32 - NUM_PLAT_IRQ)) << 16);
    localparam logic [31:0] IRQ_MASK  = 32'h0000_0888 | PLAT_MASK;

    // CSR read-modify-write operand combination.
    function automatic logic [31:0] csr_modify(input logic [1:0] op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
        case (op)
            2'b01:   return operand;
            2'b10:   return old_val | operand;
            default: return old_val & ~operand;
        endcase
    endfunction

    // Reserved vectoring modes 2 and 3 collapse to direct mode.
    function automatic logic [31:0] mtvec_legalize(input logic [31:0] v);
        return v[1] ? {v[31:2], 2'b00} : v;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] v);
        return v & 32'hFFFF_FFFC;
    endfunction

    // Fixed priority: external, software, timer, then platform lines lowest first.
    function automatic logic [4:0] irq_cause(input logic [31:0] p);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 31; i >= 16; i--) begin
            if (p[i]) c = 5'(i);
        end
        if (p[7])  c = 5'd7;
        if (p[3])  c = 5'd3;
        if (p[11]) c = 5'd11;
        return c;
    endfunction

    logic        mst_mie_q;
    logic        mst_mpie_q;
    logic [31:0] mie_q;
    logic [31:0] mip_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] mstatus_rd;
    logic [31:0] rd_val;
    logic        csr_hit;
    logic        csr_we;
    logic [31:0] wr_val;
    logic [31:0] mip_next;
    logic [31:0] pend;
    logic [4:0]  cause;
    logic        irq_take;
    logic [31:0] trap_base;
    logic [31:0] trap_pc;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};

    // Address decode and old-value read mux.
    always_comb begin
        csr_hit = 1'b1;
        rd_val  = 32'h0;
        case (csr_addr)
            ADDR_MSTATUS:   rd_val = mstatus_rd;
            ADDR_MIE:       rd_val = mie_q;
            ADDR_MTVEC:     rd_val = mtvec_q;
            ADDR_MSCRATCH:  rd_val = mscratch_q;
            ADDR_MEPC:      rd_val = mepc_q;
            ADDR_MCAUSE:    rd_val = mcause_q;
            ADDR_MIP:       rd_val = mip_q;
            ADDR_MCYCLE:    rd_val = HAS_COUNTERS ? mcycle_q[31:0]   : 32'h0;
            ADDR_MCYCLEH:   rd_val = HAS_COUNTERS ? mcycle_q[63:32]  : 32'h0;
            ADDR_MINSTRET:  rd_val = HAS_COUNTERS ? minstret_q[31:0] : 32'h0;
            ADDR_MINSTRETH: rd_val = HAS_COUNTERS ? minstret_q[63:32] : 32'h0;
            default:        csr_hit = 1'b0;
        endcase
    end

    assign csr_rdata   = (csr_op != 2'b00) ? rd_val : 32'h0;
    assign csr_illegal = (csr_op != 2'b00) && !csr_hit;
    assign csr_we      = (csr_op != 2'b00) && csr_hit;
    assign wr_val      = csr_modify(csr_op, rd_val, csr_wdata);

    // Map the raw interrupt lines onto their mip bit positions.
    always_comb begin
        mip_next     = 32'h0;
        mip_next[3]  = sw_irq;
        mip_next[7]  = timer_irq;
        mip_next[11] = ext_irq;
        for (int k = 0; k < NUM_PLAT_IRQ; k++) begin
            mip_next[16+k] = plat_irq[k];
        end
    end

    assign pend      = mip_q & mie_q;
    assign cause     = irq_cause(pend);
    assign irq_take  = rst_n && mst_mie_q && (|pend) && !is_mret;
    assign trap_base = {mtvec_q[31:2], 2'b00};
    assign trap_pc   = trap_base + ((mtvec_q[1:0] == 2'b01) ? {25'b0, cause, 2'b00} : 32'h0);

    assign trap_taken     = irq_take;
    assign redirect_valid = rst_n && (is_mret || irq_take);
    assign redirect_pc    = is_mret ? mepc_q : trap_pc;

    // mstatus MIE/MPIE: trap entry and mret take precedence over CSR writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
        end else if (irq_take) begin
            mst_mpie_q <= mst_mie_q;
            mst_mie_q  <= 1'b0;
        end else if (is_mret) begin
            mst_mie_q  <= mst_mpie_q;
            mst_mpie_q <= 1'b1;
        end else if (csr_we && csr_addr == ADDR_MSTATUS) begin
            mst_mie_q  <= wr_val[3];
            mst_mpie_q <= wr_val[7];
        end
    end

    // Software-visible CSRs without trap side effects, plus the mip sampler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 32'h0;
            mip_q      <= 32'h0;
            mtvec_q    <= 32'h0;
            mscratch_q <= 32'h0;
        end else begin
            mip_q <= mip_next & IRQ_MASK;
            if (csr_we && csr_addr == ADDR_MIE)      mie_q      <= wr_val & IRQ_MASK;
            if (csr_we && csr_addr == ADDR_MTVEC)    mtvec_q    <= mtvec_legalize(wr_val);
            if (csr_we && csr_addr == ADDR_MSCRATCH) mscratch_q <= wr_val;
        end
    end

    // mepc/mcause: trap entry overrides a same-cycle CSR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
        end else if (irq_take) begin
            mepc_q   <= word_align(pc_i);
            mcause_q <= {1'b1, 26'b0, cause};
        end else begin
            if (csr_we && csr_addr == ADDR_MEPC)   mepc_q   <= word_align(wr_val);
            if (csr_we && csr_addr == ADDR_MCAUSE) mcause_q <= wr_val;
        end
    end

    // 64-bit counters; a write to either half suppresses that counter's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else if (!HAS_COUNTERS) begin
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            if (csr_we && csr_addr == ADDR_MCYCLE)
                mcycle_q[31:0] <= wr_val;
            else if (csr_we && csr_addr == ADDR_MCYCLEH)
                mcycle_q[63:32] <= wr_val;
            else
                mcycle_q <= mcycle_q + 64'd1;

            if (csr_we && csr_addr == ADDR_MINSTRET)
                minstret_q[31:0] <= wr_val;
            else if (csr_we && csr_addr == ADDR_MINSTRETH)
                minstret_q[63:32] <= wr_val;
            else if (instr_retire && !irq_take)
                minstret_q <= minstret_q + 64'd1;
        end
    end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Testbench for csr_irq_unit: directed vector table, hand-written trap/mret
// sequences and randomized traffic checked against a behavioural CSR model.
module tb_csr_irq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] pc_i;
    logic        instr_retire;
    logic        is_mret;
    logic        timer_irq;
    logic        sw_irq;
    logic        ext_irq;
    logic [3:0]  plat_irq;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_taken;

    int n_chk  = 0;
    int n_fail = 0;

    csr_irq_unit #(.NUM_PLAT_IRQ(4), .HAS_COUNTERS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .pc_i(pc_i), .instr_retire(instr_retire), .is_mret(is_mret),
        .timer_irq(timer_irq), .sw_irq(sw_irq), .ext_irq(ext_irq), .plat_irq(plat_irq),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_taken(trap_taken)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;
    int prio[7] = '{11, 3, 7, 16, 17, 18, 19};

    task automatic model_reset();
        m_mstatus = 32'h1800; m_mie = 0; m_mip = 0; m_mtvec = 0;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mcycle = 0; m_minstret = 0;
    endtask

    function automatic logic [32:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, m_mstatus};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h344: return {1'b1, m_mip};
            12'hB00: return {1'b1, m_mcycle[31:0]};
            12'hB80: return {1'b1, m_mcycle[63:32]};
            12'hB02: return {1'b1, m_minstret[31:0]};
            12'hB82: return {1'b1, m_minstret[63:32]};
            default: return 33'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: compare DUT outputs with the model, then advance the model.
    task automatic tick();
        logic [32:0] rd;
        logic [31:0] e_rdata, pend, e_pc, nv, old_ms;
        bit          e_ill, e_take, e_valid, wr_cyc, wr_ret;
        int          cause;
        #1;
        rd      = model_read(csr_addr);
        e_ill   = (csr_op != 2'b00) && !rd[32];
        e_rdata = (csr_op != 2'b00) ? rd[31:0] : 32'h0;
        pend    = m_mip & m_mie;
        cause   = -1;
        foreach (prio[i]) if (cause < 0 && pend[prio[i]]) cause = prio[i];
        e_take  = m_mstatus[3] && (cause >= 0) && !is_mret;
        e_valid = is_mret || e_take;
        e_pc    = is_mret ? m_mepc :
                  ((m_mtvec & ~32'h3) + ((m_mtvec[1:0] == 2'b01) ? 32'(4 * cause) : 32'h0));
        chk("model_rdata", csr_rdata, e_rdata);
        chk("model_illegal", csr_illegal, e_ill);
        chk("model_trap_taken", trap_taken, e_take);
        chk("model_redirect_valid", redirect_valid, e_valid);
        if (e_valid) chk("model_redirect_pc", redirect_pc, e_pc);
        @(posedge clk);
        old_ms = m_mstatus;
        wr_cyc = 0;
        wr_ret = 0;
        if (csr_op != 2'b00 && rd[32]) begin
            case (csr_op)
                2'b01:   nv = csr_wdata;
                2'b10:   nv = rd[31:0] | csr_wdata;
                default: nv = rd[31:0] & ~csr_wdata;
            endcase
            case (csr_addr)
                12'h300: m_mstatus  = 32'h1800 | (nv & 32'h88);
                12'h304: m_mie      = nv & 32'h000F_0888;
                12'h305: m_mtvec    = (nv[1:0] >= 2'd2) ? (nv & ~32'h3) : nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & ~32'h3;
                12'h342: m_mcause   = nv;
                12'hB00: begin m_mcycle[31:0]    = nv; wr_cyc = 1; end
                12'hB80: begin m_mcycle[63:32]   = nv; wr_cyc = 1; end
                12'hB02: begin m_minstret[31:0]  = nv; wr_ret = 1; end
                12'hB82: begin m_minstret[63:32] = nv; wr_ret = 1; end
                default: ;
            endcase
        end
        if (!wr_cyc) m_mcycle = m_mcycle + 1;
        if (!wr_ret && instr_retire && !e_take) m_minstret = m_minstret + 1;
        if (e_take) begin
            m_mepc    = pc_i & ~32'h3;
            m_mcause  = 32'h8000_0000 | 32'(cause);
            m_mstatus = 32'h1800 | (old_ms[3] ? 32'h80 : 32'h0);
        end else if (is_mret) begin
            m_mstatus = 32'h1880 | (old_ms[7] ? 32'h8 : 32'h0);
        end
        m_mip = {12'b0, plat_irq, 4'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};
        @(negedge clk);
    endtask

    task automatic csr_do(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_addr = a; csr_op = op; csr_wdata = d;
        tick();
        csr_op = 2'b00;
    endtask

    task automatic csr_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a; csr_op = 2'b10; csr_wdata = 32'h0;
        #1 chk(name, csr_rdata, exp);
        tick();
        csr_op = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        csr_addr = 0; csr_op = 0; csr_wdata = 0; pc_i = 0; instr_retire = 0;
        is_mret = 0; timer_irq = 0; sw_irq = 0; ext_irq = 0; plat_irq = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        csr_addr = 12'h300; csr_op = 2'b10;
        #1;
        chk("rst_trap_taken", trap_taken, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_mstatus", csr_rdata, 32'h1800);
        csr_op = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t tbl[22];

    logic [11:0] addr_list[12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0};

    initial begin
        tbl[0]  = '{12'h300, 2'b01, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0};
        tbl[1]  = '{12'h300, 2'b11, 32'h0000_0008, 32'h0000_1888, 1'b0};
        tbl[2]  = '{12'h300, 2'b10, 32'h0000_0000, 32'h0000_1880, 1'b0};
        tbl[3]  = '{12'h304, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[4]  = '{12'h304, 2'b11, 32'h0000_0880, 32'h000F_0888, 1'b0};
        tbl[5]  = '{12'h304, 2'b10, 32'h0000_0000, 32'h000F_0008, 1'b0};
        tbl[6]  = '{12'h344, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[7]  = '{12'h344, 2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[8]  = '{12'h341, 2'b01, 32'h1234_5677, 32'h0000_0000, 1'b0};
        tbl[9]  = '{12'h341, 2'b10, 32'h0000_0000, 32'h1234_5674, 1'b0};
        tbl[10] = '{12'h305, 2'b01, 32'h0000_0102, 32'h0000_0000, 1'b0};
        tbl[11] = '{12'h305, 2'b10, 32'h0000_0003, 32'h0000_0100, 1'b0};
        tbl[12] = '{12'h305, 2'b10, 32'h0000_0000, 32'h0000_0100, 1'b0};
        tbl[13] = '{12'h340, 2'b01, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[14] = '{12'h340, 2'b11, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0};
        tbl[15] = '{12'h340, 2'b10, 32'h0000_0000, 32'hDEAD_0000, 1'b0};
        tbl[16] = '{12'h342, 2'b01, 32'h8000_000B, 32'h0000_0000, 1'b0};
        tbl[17] = '{12'h342, 2'b10, 32'h0000_0000, 32'h8000_000B, 1'b0};
        tbl[18] = '{12'h7C0, 2'b01, 32'h0000_0005, 32'h0000_0000, 1'b1};
        tbl[19] = '{12'h301, 2'b10, 32'h0000_0005, 32'h0000_0000, 1'b1};
        tbl[20] = '{12'h7C0, 2'b00, 32'h0000_0005, 32'h0000_0000, 1'b0};
        tbl[21] = '{12'h304, 2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0};

        do_reset();

        // Field masks and address map from the vector table.
        for (int i = 0; i < 22; i++) begin
            csr_addr = tbl[i].addr; csr_op = tbl[i].op; csr_wdata = tbl[i].wdata;
            #1;
            chk($sformatf("tbl%0d_rdata", i), csr_rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_illegal", i), csr_illegal, tbl[i].exp_ill);
            tick();
        end
        csr_op = 2'b00;

        // mtvec write and mode legalization after a fresh reset.
        do_reset();
        csr_chk("rst_mie", 12'h304, 32'h0);
        csr_chk("rst_mip", 12'h344, 32'h0);
        csr_do(12'h305, 2'b01, 32'h0000_1001);
        csr_chk("mtvec_vec", 12'h305, 32'h0000_1001);
        csr_do(12'h305, 2'b01, 32'h0000_2003);
        csr_chk("mtvec_mode3", 12'h305, 32'h0000_2000);

        // External beats timer, direct mode.
        csr_do(12'h305, 2'b01, 32'h100);
        csr_do(12'h304, 2'b01, 32'h880);
        csr_do(12'h300, 2'b01, 32'h8);
        pc_i = 32'h40; timer_irq = 1; ext_irq = 1;
        #1 chk("irq_latency", trap_taken, 0);
        tick();
        #1;
        chk("ext_trap_taken", trap_taken, 1);
        chk("ext_redirect_pc", redirect_pc, 32'h100);
        tick();
        timer_irq = 0; ext_irq = 0;
        csr_chk("ext_mcause", 12'h342, 32'h8000_000B);
        csr_chk("ext_mepc", 12'h341, 32'h40);
        csr_chk("ext_mstatus", 12'h300, 32'h1880);

        // Timer only, vectored mode.
        csr_do(12'h305, 2'b01, 32'h101);
        csr_do(12'h300, 2'b01, 32'h8);
        timer_irq = 1;
        tick();
        #1;
        chk("tmr_trap_taken", trap_taken, 1);
        chk("tmr_redirect_pc", redirect_pc, 32'h11C);
        tick();
        csr_chk("tmr_mcause", 12'h342, 32'h8000_0007);

        // mret with the timer still pending, then re-entry.
        is_mret = 1;
        #1;
        chk("mret_valid", redirect_valid, 1);
        chk("mret_pc", redirect_pc, 32'h40);
        chk("mret_no_trap", trap_taken, 0);
        tick();
        is_mret = 0;
        csr_addr = 12'h300; csr_op = 2'b10; csr_wdata = 0;
        #1;
        chk("post_mret_mstatus", csr_rdata, 32'h1888);
        chk("retake_trap", trap_taken, 1);
        chk("retake_pc", redirect_pc, 32'h11C);
        tick();
        csr_op = 0; timer_irq = 0;
        csr_chk("retake_mstatus", 12'h300, 32'h1880);

        // Platform lines: lowest index wins, masking in mie shifts the cause.
        csr_do(12'h304, 2'b01, 32'h3_0000);
        csr_do(12'h300, 2'b01, 32'h8);
        plat_irq = 4'b0011;
        tick();
        #1;
        chk("plat16_trap", trap_taken, 1);
        chk("plat16_pc", redirect_pc, 32'h140);
        tick();
        csr_do(12'h304, 2'b11, 32'h1_0000);
        csr_chk("plat_mie", 12'h304, 32'h2_0000);
        is_mret = 1;
        #1 chk("plat_mret_pc", redirect_pc, 32'h40);
        tick();
        is_mret = 0;
        #1;
        chk("plat17_trap", trap_taken, 1);
        chk("plat17_pc", redirect_pc, 32'h144);
        tick();
        csr_chk("plat17_mcause", 12'h342, 32'h8000_0011);
        plat_irq = 0;

        // mcycle carry across the half boundary.
        csr_do(12'hB00, 2'b01, 32'hFFFF_FFFF);
        csr_do(12'hB80, 2'b01, 32'h0);
        csr_chk("mcycleh_written", 12'hB80, 32'h0);
        csr_chk("mcycle_held", 12'hB00, 32'hFFFF_FFFF);
        tick();
        csr_chk("mcycleh_carry", 12'hB80, 32'h1);
        csr_chk("mcycle_wrapped", 12'hB00, 32'h0);

        // Unimplemented address: flagged, no state change.
        csr_do(12'h340, 2'b01, 32'h1234);
        csr_addr = 12'h7C0; csr_op = 2'b01; csr_wdata = 32'hFFFF_FFFF;
        #1;
        chk("illegal_flag", csr_illegal, 1);
        chk("illegal_rdata", csr_rdata, 0);
        tick();
        csr_op = 0;
        csr_chk("illegal_nochange", 12'h340, 32'h1234);

        // Asynchronous reset drops a trap that is being taken.
        csr_do(12'h300, 2'b01, 32'h8);
        plat_irq = 4'b0010;
        tick();
        #1 chk("pre_rst_trap", trap_taken, 1);
        #1 rst_n = 0;
        #1;
        chk("async_rst_trap", trap_taken, 0);
        chk("async_rst_redirect", redirect_valid, 0);
        model_reset();
        plat_irq = 0;
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            csr_addr     = addr_list[$urandom_range(0, 11)];
            csr_op       = 2'($urandom);
            csr_wdata    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            pc_i         = $urandom & 32'hFFFF_FFFC;
            instr_retire = 1'($urandom);
            is_mret      = ($urandom_range(0, 7) == 0);
            timer_irq    = ($urandom_range(0, 3) == 0);
            sw_irq       = ($urandom_range(0, 3) == 0);
            ext_irq      = ($urandom_range(0, 5) == 0);
            plat_irq     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if (is_mret && csr_addr == 12'h300) csr_op = 2'b00;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
